// File: rtl/cla_pipe_addsub.sv
// Pipelined WIDTH-bit carry-look-ahead add/sub, one GROUP-bit look-ahead group per stage; latency WIDTH/GROUP.
// Stalls as a single rigid pipe: when the output is held, every stage holds and in_ready drops.
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NSTAGE = WIDTH / GROUP;

  // Layer 0 holds the prepared operands; layer k+1 holds the result of stage k.
  logic [NSTAGE:0]  r_vld;
  logic [WIDTH-1:0] r_a  [0:NSTAGE-1];
  logic [WIDTH-1:0] r_bx [0:NSTAGE-1];
  logic [WIDTH-1:0] r_s  [1:NSTAGE];
  logic             r_c  [0:NSTAGE];
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;
  logic [WIDTH-1:0] w_snext [0:NSTAGE-1];
  logic             w_cout  [0:NSTAGE-1];
  logic             w_ovf;

  // Two-level AND-OR expansion of every carry, not a ripple recurrence.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_cv;
    logic [WIDTH-1:0] w_prev;

    assign w_g  = r_a[k][k*GROUP +: GROUP] & r_bx[k][k*GROUP +: GROUP];
    assign w_p  = r_a[k][k*GROUP +: GROUP] ^ r_bx[k][k*GROUP +: GROUP];
    assign w_cv = cla_carries(w_g, w_p, r_c[k]);

    if (k == 0) begin : g_first
      assign w_prev = '0;
    end else begin : g_next
      assign w_prev = r_s[k];
    end

    always_comb begin
      w_snext[k] = w_prev;
      w_snext[k][k*GROUP +: GROUP] = w_p ^ w_cv[GROUP-1:0];
    end
    assign w_cout[k] = w_cv[GROUP];

    if (k == NSTAGE - 1) begin : g_last
      assign w_ovf = w_cv[GROUP-1] ^ w_cv[GROUP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        r_a[k]  <= '0;
        r_bx[k] <= '0;
      end
      for (int k = 1; k <= NSTAGE; k++) r_s[k] <= '0;
      for (int k = 0; k <= NSTAGE; k++) r_c[k] <= 1'b0;
    end else begin
      if (flush) begin
        r_vld <= '0;
      end else if (w_adv) begin
        r_vld <= {r_vld[NSTAGE-1:0], in_valid};
      end
      // Data moves even during flush; only the valid bits matter afterwards.
      if (w_adv) begin
        r_a[0]  <= a;
        r_bx[0] <= sub ? ~b : b;
        r_c[0]  <= sub | cin;
        for (int k = 0; k < NSTAGE - 1; k++) begin
          r_a[k+1]  <= r_a[k];
          r_bx[k+1] <= r_bx[k];
        end
        for (int k = 0; k < NSTAGE; k++) begin
          r_s[k+1] <= w_snext[k];
          r_c[k+1] <= w_cout[k];
        end
        r_ovf  <= w_ovf;
        r_zero <= ~|w_snext[NSTAGE-1];
      end
    end
  end

  assign out_valid = r_vld[NSTAGE];
  assign sum       = r_s[NSTAGE];
  assign cout      = r_c[NSTAGE];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub at WIDTH=16, GROUP=4: arithmetic, latency, stall, flush, reset.
module tb_cla_pipe_addsub;
  localparam int WIDTH  = 16;
  localparam int GROUP  = 4;
  localparam int NSTAGE = WIDTH / GROUP;

  logic             clk, rst_n, flush, in_valid, in_ready, cin, sub;
  logic             out_valid, out_ready, cout, ovf, zero;
  logic [WIDTH-1:0] a, b, sum;

  int n_vec  = 0;
  int n_fail = 0;

  cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-pressure vectors; expected packed as {cout, ovf, zero, sum}.
  logic [15:0] bp_a [8] = '{16'h1111, 16'hF000, 16'h4000, 16'h0003, 16'h0001, 16'h1234, 16'h8000, 16'hABCD};
  logic [15:0] bp_b [8] = '{16'h2222, 16'h1000, 16'h4000, 16'h0003, 16'h0002, 16'h0001, 16'h8000, 16'h1111};
  logic        bp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        bp_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [18:0] bp_e [8] = '{19'h03333, 19'h50000, 19'h28000, 19'h50000,
                            19'h0FFFF, 19'h01236, 19'h70000, 19'h0BCDE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res();
    return {13'b0, cout, ovf, zero, sum};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic oc, input logic os, input logic [18:0] exp);
    int lat;
    lat = 0;
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(NSTAGE));
    chk(tag, res(), {13'b0, exp});
  endtask

  initial begin
    int in_idx, out_idx, first, last;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset flags/sum", res(), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 19'h00100);
    run_op("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 19'h50000);
    run_op("add 7FFF+0+cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 19'h28000);
    run_op("sub 0005-0007", 16'h0005, 16'h0007, 1'b1, 1'b1, 19'h0FFFE);
    run_op("sub 8000-0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 19'h67FFF);
    run_op("sub 1234-1234", 16'h1234, 16'h1234, 1'b0, 1'b1, 19'h50000);
    @(posedge clk); #1;

    // Back-to-back ops with a 3-cycle output stall.
    in_idx = 0; out_idx = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (in_idx < 8);
      if (in_idx < 8) begin
        a = bp_a[in_idx]; b = bp_b[in_idx]; cin = bp_c[in_idx]; sub = bp_s[in_idx];
      end
      #1;
      if (!out_ready && out_valid) chk("stall in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp result %0d", out_idx), res(), {13'b0, bp_e[out_idx]});
        if (first < 0) first = cyc;
        last = cyc;
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp result count", 32'(out_idx), 32'd8);
    chk("bp output span", 32'(last - first), 32'd10);

    // Flush with three ops in flight; the op presented during flush is dropped too.
    for (int i = 0; i < 3; i++) begin
      a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1 chk("flush in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush out_valid +%0d", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Async reset while a result sits at the output.
    for (int i = 0; i < 3; i++) begin
      a = 16'h0010 << i; b = 16'h0020; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    chk("pre-reset result", res(), 32'h00030);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(out_valid), 32'd0);
    chk("mid reset flags/sum", res(), 32'd0);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("post-reset stale result", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
